// File: rtl/io_shield_frontend_if.sv
// Shield pin bundle: raw buttons and DIP switches in, LED and 7-segment drive out.
// The master side is the board and pins; the slave side is the front-end controller.
interface io_shield_frontend_if;
    logic [4:0]  io_button;
    logic [23:0] io_dip;
    logic [23:0] io_led;
    logic [7:0]  io_seg;
    logic [3:0]  io_sel;

    modport master (
        output io_button,
        output io_dip,
        input  io_led,
        input  io_seg,
        input  io_sel
    );

    modport slave (
        input  io_button,
        input  io_dip,
        output io_led,
        output io_seg,
        output io_sel
    );
endinterface

// File: rtl/io_shield_frontend.sv
// IO Shield front-panel controller.
// Debounces the D-pad buttons and DIP switches, mirrors dip[23:8] onto the LEDs and
// the 4-digit hex display, and runs a button-driven 8-bit counter on io_led[7:0]
// with 4-bit PWM dimming.

// Vector debouncer: a 2-flop synchronizer and a stability counter per bit.
// 'pressed' pulses for one cycle on a 0->1 change of 'level'; 'released' on 1->0.
module io_shield_debounce #(
    parameter int WIDTH = 1,
    parameter int BITS  = 20
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] raw,
    output logic [WIDTH-1:0] level,
    output logic [WIDTH-1:0] pressed,
    output logic [WIDTH-1:0] released
);
    logic [WIDTH-1:0] sync_a;
    logic [WIDTH-1:0] sync_b;

    // Two-stage synchronizer for the asynchronous pin values.
    // NOTE: sequential state is always assigned with <= so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_a <= '0;
            sync_b <= '0;
        end else begin
            sync_a <= raw;
            sync_b <= sync_a;
        end
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        logic [BITS-1:0] count;
        logic            level_q;
        logic            pressed_q;
        logic            released_q;

        // Stability counter: restarts on agreement, commits the new value once it saturates.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                count      <= '0;
                level_q    <= 1'b0;
                pressed_q  <= 1'b0;
                released_q <= 1'b0;
            end else begin
                pressed_q  <= 1'b0;
                released_q <= 1'b0;
                if (sync_b[i] == level_q) begin
                    count <= '0;
                end else begin
                    // Wraps to zero on the commit cycle, matching the restart on agreement.
                    count <= count + 1'b1;
                    if (&count) begin
                        level_q    <= sync_b[i];
                        pressed_q  <= sync_b[i];
                        released_q <= ~sync_b[i];
                    end
                end
            end
        end

        assign level[i]    = level_q;
        assign pressed[i]  = pressed_q;
        assign released[i] = released_q;
    end
endmodule

module io_shield_frontend #(
    parameter int DEBOUNCE_BITS = 20,
    parameter int REFRESH_BITS  = 18,
    parameter int PWM_BITS      = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    io_shield_frontend_if.slave   pins
);
    typedef enum logic [2:0] {
        BTN_UP     = 3'd0,
        BTN_CENTER = 3'd1,
        BTN_DOWN   = 3'd2,
        BTN_LEFT   = 3'd3,
        BTN_RIGHT  = 3'd4
    } button_e;

    localparam logic [PWM_BITS-1:0] PWM_MIN = PWM_BITS'(1);
    localparam logic [PWM_BITS-1:0] PWM_MAX = '1;

    logic [4:0]  btn_level;
    logic [4:0]  btn_pressed;
    logic [4:0]  btn_released;
    logic [23:0] dip_level;
    logic [23:0] dip_pressed;
    logic [23:0] dip_released;

    logic [7:0]              led_value;
    logic [PWM_BITS-1:0]     pwm_value;
    logic [PWM_BITS-1:0]     pwm_count;
    logic [REFRESH_BITS-1:0] refresh_count;
    logic                    pwm_out;
    logic [1:0]              digit;
    logic [3:0]              nibble;
    logic [6:0]              glyph;

    io_shield_debounce #(.WIDTH(5), .BITS(DEBOUNCE_BITS)) u_button_db (
        .clk      (clk),
        .rst_n    (rst_n),
        .raw      (pins.io_button),
        .level    (btn_level),
        .pressed  (btn_pressed),
        .released (btn_released)
    );

    io_shield_debounce #(.WIDTH(24), .BITS(DEBOUNCE_BITS)) u_dip_db (
        .clk      (clk),
        .rst_n    (rst_n),
        .raw      (pins.io_dip),
        .level    (dip_level),
        .pressed  (dip_pressed),
        .released (dip_released)
    );

    // Low DIP bits and all release pulses have no consumer on this board.
    logic unused_ok;
    assign unused_ok = &{1'b0, dip_level[7:0], dip_pressed, dip_released, btn_released,
                         btn_pressed[BTN_CENTER]};

    // Button-driven counter: up beats down, and either press beats the center clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            led_value <= 8'h00;
        end else if (btn_pressed[BTN_UP]) begin
            led_value <= led_value + 8'd1;
        end else if (btn_pressed[BTN_DOWN]) begin
            led_value <= led_value - 8'd1;
        end else if (btn_level[BTN_CENTER]) begin
            led_value <= 8'h00;
        end
    end

    // Brightness level, clamped to [1, max] so the counter LEDs never go fully dark.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pwm_value <= PWM_MAX;
        end else if (btn_pressed[BTN_LEFT] && (pwm_value > PWM_MIN)) begin
            pwm_value <= pwm_value - PWM_MIN;
        end else if (btn_pressed[BTN_RIGHT] && (pwm_value < PWM_MAX)) begin
            pwm_value <= pwm_value + PWM_MIN;
        end
    end

    // Free-running PWM and display refresh timebases.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pwm_count     <= '0;
            refresh_count <= '0;
        end else begin
            pwm_count     <= pwm_count + 1'b1;
            refresh_count <= refresh_count + 1'b1;
        end
    end

    assign pwm_out = (pwm_count < pwm_value);
    assign digit   = refresh_count[REFRESH_BITS-1 -: 2];

    // Digit nibble select and active-low hex glyph lookup (lowercase b and d).
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        nibble = dip_level[11:8];
        glyph  = 7'b1000000;
        case (digit)
            2'd0: nibble = dip_level[11:8];
            2'd1: nibble = dip_level[15:12];
            2'd2: nibble = dip_level[19:16];
            2'd3: nibble = dip_level[23:20];
            default: nibble = dip_level[11:8];
        endcase
        case (nibble)
            4'h0: glyph = 7'b1000000;
            4'h1: glyph = 7'b1111001;
            4'h2: glyph = 7'b0100100;
            4'h3: glyph = 7'b0110000;
            4'h4: glyph = 7'b0011001;
            4'h5: glyph = 7'b0010010;
            4'h6: glyph = 7'b0000010;
            4'h7: glyph = 7'b1111000;
            4'h8: glyph = 7'b0000000;
            4'h9: glyph = 7'b0010000;
            4'hA: glyph = 7'b0001000;
            4'hB: glyph = 7'b0000011;
            4'hC: glyph = 7'b1000110;
            4'hD: glyph = 7'b0100001;
            4'hE: glyph = 7'b0000110;
            4'hF: glyph = 7'b0001110;
            default: glyph = 7'b1000000;
        endcase
    end

    // Select and segments both derive from the same registered digit, so they switch together.
    assign pins.io_sel = ~(4'b0001 << digit);
    assign pins.io_seg = {1'b1, glyph};
    assign pins.io_led = {dip_level[23:8], led_value & {8{pwm_out}}};
endmodule

// File: tb/tb_io_shield_frontend.sv
// Directed bench for io_shield_frontend with short debounce and refresh counters.
module tb_io_shield_frontend;
    localparam int DB = 4;
    localparam int RB = 4;
    localparam int PB = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    io_shield_frontend_if pins ();

    io_shield_frontend #(
        .DEBOUNCE_BITS (DB),
        .REFRESH_BITS  (RB),
        .PWM_BITS      (PB)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .pins  (pins)
    );

    int checks = 0;
    int passes = 0;
    int fails  = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Hold a button long enough to debounce, then release and let it settle.
    task automatic press(input int idx);
        @(negedge clk);
        pins.io_button[idx] = 1'b1;
        repeat (30) @(negedge clk);
        pins.io_button[idx] = 1'b0;
        repeat (30) @(negedge clk);
    endtask

    task automatic press_n(input int idx, input int n);
        for (int i = 0; i < n; i++) press(idx);
    endtask

    // One full PWM period: OR of the low LED bank and number of lit cycles.
    task automatic measure(output logic [7:0] orv, output int on);
        orv = 8'h00;
        on  = 0;
        repeat (16) begin
            @(negedge clk);
            orv = orv | pins.io_led[7:0];
            if (pins.io_led[7:0] != 8'h00) on++;
        end
    endtask

    task automatic check_bank(input string tag, input logic [7:0] exp_val, input int exp_on);
        logic [7:0] orv;
        int on;
        measure(orv, on);
        check({tag, "_value"}, 32'(orv), 32'(exp_val));
        check({tag, "_duty"}, 32'(on), 32'(exp_on));
    endtask

    // Wait (bounded) for digit k to become active, then check its segments.
    task automatic check_digit(input int k, input logic [7:0] exp_seg);
        logic [3:0] want;
        bit found;
        want  = ~(4'b0001 << k);
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk);
            if (pins.io_sel == want) found = 1'b1;
        end
        if (!found) check($sformatf("digit%0d_reached", k), 32'(pins.io_sel), 32'(want));
        else check($sformatf("digit%0d_seg", k), 32'(pins.io_seg), 32'(exp_seg));
    endtask

    initial begin
        logic [3:0] exp_sel;
        pins.io_button = 5'b0;
        pins.io_dip    = 24'h0;
        rst_n          = 1'b0;
        repeat (2) @(negedge clk);

        // Reset state.
        check("rst_led", 32'(pins.io_led), 32'h0);
        check("rst_sel", 32'(pins.io_sel), 32'hE);
        check("rst_seg", 32'(pins.io_seg), 32'hC0);

        // Release and watch the digit scan: 4 cycles per digit, 0,1,2,3.
        rst_n = 1'b1;
        for (int i = 0; i < 16; i++) begin
            exp_sel = ~(4'b0001 << (i / 4));
            check($sformatf("scan_sel_%0d", i), 32'(pins.io_sel), 32'(exp_sel));
            @(negedge clk);
        end
        check("idle_seg", 32'(pins.io_seg), 32'hC0);
        check("idle_led", 32'(pins.io_led), 32'h0);

        // DIP path: LEDs and hex digits.
        pins.io_dip = 24'hA5_3C_00;
        repeat (25) @(negedge clk);
        check("dip_led_hi", 32'(pins.io_led[23:8]), 32'hA53C);
        check("dip_led_lo", 32'(pins.io_led[7:0]), 32'h00);
        check_digit(3, 8'h88);
        check_digit(0, 8'hC6);
        check_digit(1, 8'hB0);
        check_digit(2, 8'h92);

        // Up x3, down x1 -> 2, lit 15 of 16 cycles.
        press_n(0, 3);
        press(2);
        check_bank("count_2", 8'h02, 15);

        // Center held clears.
        @(negedge clk);
        pins.io_button[1] = 1'b1;
        repeat (25) @(negedge clk);
        check_bank("center_clr", 8'h00, 0);
        pins.io_button[1] = 1'b0;
        repeat (30) @(negedge clk);

        // Down from 0 wraps to FF; up from FF wraps to 00.
        press(2);
        check_bank("wrap_ff", 8'hFF, 15);
        press(0);
        check_bank("wrap_00", 8'h00, 0);
        press(2);
        check_bank("wrap_ff2", 8'hFF, 15);

        // Hold center: stays 0 for as long as it is held.
        @(negedge clk);
        pins.io_button[1] = 1'b1;
        repeat (25) @(negedge clk);
        check_bank("center_hold_a", 8'h00, 0);
        check_bank("center_hold_b", 8'h00, 0);
        pins.io_button[1] = 1'b0;
        repeat (30) @(negedge clk);

        // Brightness: 15 -> 8 -> clamps at 1 -> clamps at 15.
        press(0);
        check_bank("count_1", 8'h01, 15);
        press_n(3, 7);
        check_bank("pwm_8", 8'h01, 8);
        press_n(3, 13);
        check_bank("pwm_min", 8'h01, 1);
        press_n(4, 20);
        check_bank("pwm_max", 8'h01, 15);

        // Short glitch on up is ignored.
        @(negedge clk);
        pins.io_button[0] = 1'b1;
        repeat (3) @(negedge clk);
        pins.io_button[0] = 1'b0;
        repeat (40) @(negedge clk);
        check_bank("glitch", 8'h01, 15);

        // Build some state, then reset mid-operation.
        press_n(0, 2);
        press_n(3, 4);
        check_bank("pre_rst", 8'h03, 11);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_led", 32'(pins.io_led), 32'h0);
        check("midrst_sel", 32'(pins.io_sel), 32'hE);
        check("midrst_seg", 32'(pins.io_seg), 32'hC0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("post_rst_led", 32'(pins.io_led), 32'h0);
        repeat (25) @(negedge clk);
        check("rebuilt_dip", 32'(pins.io_led[23:8]), 32'hA53C);
        press(0);
        check_bank("post_rst_pwm", 8'h01, 15);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule

// File: doc/io_shield_frontend.md
# io_shield_frontend

Front-panel controller for the IO Shield. Every raw input is debounced: five D-pad buttons and 24 DIP switches. The upper 16 DIP bits are mirrored onto LEDs and shown as four hex digits on the multiplexed 7-segment display. The block also keeps an 8-bit counter, driven by the buttons, and shows it on the low LED bank with 4-bit PWM dimming. It sits directly under the board top level, between the shield pins and the rest of the design.

## Interface
Parameters:
- DEBOUNCE_BITS, 20 — width of the debounce stability counter; an input must be stable for 2^DEBOUNCE_BITS cycles.
- REFRESH_BITS, 18 — width of the display refresh counter; the top 2 bits select the active digit.
- PWM_BITS, 4 — width of the PWM counter and of the brightness level.

Ports:
- clk  in  1  system clock, 50 MHz; the only clock.
- rst_n  in  1  asynchronous, active-low reset.
- io_button  in  5  raw buttons, active high: [0] up, [1] center, [2] down, [3] left, [4] right.
- io_dip  in  24  raw DIP switches, active high.
- io_led  out  24  LED drive, active high.
- io_seg  out  8  segment drive, active low: [6:0] = g..a, [7] = decimal point.
- io_sel  out  4  digit select, active low: [0] = rightmost digit.

## Operation
Debouncer (one per button and per DIP bit, 29 in total):
- Input passes through a 2-flop synchronizer.
- The counter resets whenever the synchronized value equals the current debounced output; otherwise it increments.
- When the counter reaches its all-ones value, the debounced output takes the synchronized value.
- `down` is a one-cycle pulse on a 0→1 change of the debounced output; `up` is a one-cycle pulse on a 1→0 change.

DIP path:
- io_led[23:8] = debounced dip[23:8].
- The hex digits show debounced dip[23:8]: digit 3 (leftmost) = [23:20] … digit 0 = [11:8].
- dip[7:0] is debounced but unused.

Hex driver:
- A free-running refresh counter's top 2 bits (k) select digit k: io_sel has only bit k low.
- io_seg[6:0] carries the active-low pattern of that nibble, using standard hex glyphs with lowercase b and d. Examples: 0 = 7'b1000000, 8 = 7'b0000000, F = 7'b0001110.
- io_seg[7] is always 1 (decimal point off).

Counter (led_value, 8 bits):
- Up pressed: +1, wrapping FF→00.
- Else down pressed: −1, wrapping 00→FF.
- Else center held (debounced level, not a pulse): led_value = 0.
- In the same cycle, an up/down press takes priority over center; up takes priority over down.

Brightness (pwm_value, 4 bits):
- Left pressed and value > 1: −1. The minimum is 1, so LEDs never go fully dark by button.
- Else right pressed and value < 15: +1. The maximum is 15.

PWM:
- Free-running PWM_BITS counter.
- pwm_out = (counter < pwm_value), so duty = pwm_value/16.
- io_led[7:0] = led_value & {8{pwm_out}}.

Reset (asynchronous, all registers):
- Synchronizers, debounced outputs, and all counters cleared to 0.
- led_value = 0; pwm_value = 15.
- Output values during reset:
  - io_led = 0.
  - io_sel = 4'b1110.
  - io_seg = 8'hC0 (digit 0 showing "0").

## Timing
- Debounce latency from a stable input change to the output: 2 (sync) + 2^DEBOUNCE_BITS cycles, ±1 cycle. A glitch shorter than 2^DEBOUNCE_BITS cycles produces no output change.
- A press pulse updates led_value or pwm_value on the next clock edge. Exactly one update occurs per press; a held button does not auto-repeat.
- Center clear applies on every cycle the debounced center level is 1, except cycles carrying an up/down pulse.
- Digit dwell = 2^(REFRESH_BITS−2) cycles, with order 0,1,2,3,0…. io_sel and io_seg change on the same edge, so there is no ghosting cycle.
- PWM period = 2^PWM_BITS cycles. A pwm_value change takes effect on the next counter compare.
- Reset assertion mid-operation clears everything immediately. Debounced state rebuilds only after the full latency from release.

## Test plan
Run with DEBOUNCE_BITS=4, REFRESH_BITS=4.
- Reset released, no inputs:
  - io_led=0, io_seg=8'hC0.
  - io_sel cycles 1110→1101→1011→0111, 4 cycles each.
- io_dip=24'hA5_3C_00 held for 20 cycles:
  - io_led[23:8]=16'hA53C.
  - Digit 3 shows A (7'b0001000); digit 0 shows C (7'b1000110).
- Up button pulsed 3 times, each long enough to debounce, then down once:
  - led_value=2.
  - io_led[7:0] is 8'h02 for 15 of every 16 cycles and 0 for 1.
- Down press from 0: led_value=FF. Then hold center: led_value=0 while held.
- Left pressed 20 times:
  - pwm_value stops at 1; io_led[7:0] is high 1 of 16 cycles.
  - Right pressed 20 times: pwm_value stops at 15.
- A 3-cycle glitch on io_button[0] produces no count change. Asserting rst_n low mid-count sets led_value=0 and pwm_value=15 immediately.
